sram_fb_reader: RTL and testbench

- Read side of the 640x480 RGB565 SRAM framebuffer, the counterpart of the framebuffer fill/writer block.
- Scans SRAM linearly, one pixel per clk50, from address 0 to H_RES*V_RES-1.
- Buffers pixels in a small FIFO and presents them, tagged with start-of-frame and end-of-line, to the video-timing consumer through a valid/read handshake.
- Drives the SRAM bus only while enable is high; otherwise tri-states it so another block can own the SRAM.

---
 rtl/fb_pkg.sv | 48 ++++
 rtl/fb_pixel_fifo.sv | 71 +++++++
 rtl/sram_fb_reader.sv | 218 +++++++++++++++++++++
 tb/tb_sram_fb_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared types and constants for the SRAM framebuffer reader:
//            default geometry, pixel and FIFO entry types, FSM state
//            encoding, and the colour-bar lookup used by the optional
//            test-pattern source (FB_BYPASS_PATTERN_EN).
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FB_PIXELS = H_RES_DEF * V_RES_DEF;

    // RGB565: {r[4:0], g[5:0], b[4:0]}
    typedef logic [15:0] pixel565_t;

    typedef struct packed {
        pixel565_t pix;
        logic      sof;
        logic      eol;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fb_state_t;

    // Eight vertical bars, left to right.
    function automatic pixel565_t bar_color(input logic [2:0] idx);
        pixel565_t c;
        case (idx)
            3'd0:    c = 16'hF800;
            3'd1:    c = 16'h07E0;
            3'd2:    c = 16'h001F;
            3'd3:    c = 16'hFFE0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'h07FF;
            3'd6:    c = 16'hFFFF;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_fifo
// Purpose  : Synchronous first-word-fall-through FIFO of fifo_entry_t.
//            The head entry is visible on o_head whenever o_empty=0 and is
//            forced to zero when empty. i_flush empties the FIFO in one edge.
// Ports    : clk, rst (async, active high), i_flush, i_push/i_data,
//            i_pop, o_head, o_count, o_full, o_empty
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_fifo
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  fifo_entry_t                 i_data,
    input  logic                        i_pop,
    output fifo_entry_t                 o_head,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fifo_entry_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    // A push into a full FIFO is accepted only if a pop frees a slot.
    assign w_push  = i_push && (!o_full || w_pop) && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/sram_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_fb_reader
// Purpose  : Linear scan reader of an RGB565 SRAM framebuffer. One read per
//            clock, pixels buffered in a FWFT FIFO and tagged with
//            start-of-frame / end-of-line for the video-timing consumer.
//            SRAM pins are tri-stated while enable=0.
// Ports    : clk50, rst (async, active high), enable, frame_start, pix_rd,
//            pix_valid/pix_data/pix_sof/pix_eol, frame_done, underflow,
//            SRAM_ADDR, SRAM_DQ (sampled only), SRAM_CE_N/OE_N/WE_N/UB_N/LB_N
// Options  : FB_BYPASS_PATTERN_EN adds input pattern_sel; when high the FIFO
//            is filled with eight colour bars instead of SRAM data.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fb_reader
    import fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 20
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              pix_rd,
`ifdef FB_BYPASS_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              underflow,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int PIXELS = H_RES * V_RES;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int X_W    = $clog2(H_RES);
    localparam int Y_W    = $clog2(V_RES);

    fb_state_t          r_state;
    fb_state_t          w_state_nxt;
    logic [ADDR_W-1:0]  r_issue_ptr;
    logic [ADDR_W-1:0]  r_commit_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic [X_W-1:0]     r_x;        // column of the next pixel to commit
    logic [Y_W-1:0]     r_y;        // line of the next pixel to commit
    logic               r_inflight; // a read was issued on the previous edge
    logic               r_underflow;

    logic               w_src_ok;
    logic               w_issue;
    logic               w_push;
    logic               w_rewind;
    logic               w_pop;
    logic               w_last;
    logic               w_oe_n;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    pixel565_t          w_pixel;
    fifo_entry_t        w_push_data;
    fifo_entry_t        w_head;

`ifdef FB_BYPASS_PATTERN_EN
    localparam int BAR_W = H_RES / 8;
    localparam int BX_W  = $clog2(BAR_W);

    logic [2:0]      r_bar;
    logic [BX_W-1:0] r_bar_x;

    // The pattern source never needs the bus, so enable does not gate it.
    assign w_src_ok = pattern_sel || enable;
    assign w_pixel  = pattern_sel ? bar_color(r_bar) : SRAM_DQ;
    assign w_oe_n   = !((r_state == ST_READ) && !pattern_sel);

    // Bar index tracks the commit column without a divider.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_bar   <= '0;
            r_bar_x <= '0;
        end else if (frame_start) begin
            r_bar   <= '0;
            r_bar_x <= '0;
        end else if (w_push) begin
            if (r_x == X_W'(H_RES-1)) begin
                r_bar   <= '0;
                r_bar_x <= '0;
            end else if (r_bar_x == BX_W'(BAR_W-1)) begin
                r_bar   <= r_bar + 3'd1;
                r_bar_x <= '0;
            end else begin
                r_bar_x <= r_bar_x + BX_W'(1);
            end
        end
    end
`else
    assign w_src_ok = enable;
    assign w_pixel  = SRAM_DQ;
    assign w_oe_n   = (r_state != ST_READ);
`endif

    assign w_last      = (r_x == X_W'(H_RES-1)) && (r_y == Y_W'(V_RES-1));
    assign w_push_data = {w_pixel, (r_commit_ptr == '0), (r_x == X_W'(H_RES-1))};
    // frame_start wins over a simultaneous consumer pop.
    assign w_pop       = pix_rd && !frame_start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state and strobes ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_rewind    = 1'b0;
        if (frame_start) begin
            w_state_nxt = ST_READ;
        end else begin
            // Data for last cycle's address is on the bus now; if the bus
            // was lost meanwhile, the read is retried from commit_ptr.
            if (r_inflight) begin
                if (w_src_ok) w_push   = 1'b1;
                else          w_rewind = 1'b1;
            end
            // Reserve a slot for the in-flight read so the FIFO never overflows.
            if ((r_state == ST_READ) && w_src_ok && !w_full &&
                ((w_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH)) &&
                (r_issue_ptr < ADDR_W'(PIXELS)))
                w_issue = 1'b1;
            if (w_push && w_last)
                w_state_nxt = ST_DONE;
        end
    end

    // ---------------- Address / commit datapath ----------------
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_issue_ptr  <= '0;
            r_commit_ptr <= '0;
            r_addr       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_inflight   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (frame_start) begin
            r_issue_ptr  <= '0;
            r_commit_ptr <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_inflight   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr      <= r_issue_ptr;
                r_issue_ptr <= r_issue_ptr + ADDR_W'(1);
            end else if (w_rewind) begin
                r_issue_ptr <= r_commit_ptr;
            end
            if (w_push) begin
                r_commit_ptr <= r_commit_ptr + ADDR_W'(1);
                if (r_x == X_W'(H_RES-1)) begin
                    r_x <= '0;
                    r_y <= r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            if (pix_rd && w_empty) r_underflow <= 1'b1;
        end
    end

    fb_pixel_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk50),
        .rst     (rst),
        .i_flush (frame_start),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign pix_valid  = !w_empty;
    assign pix_data   = w_head.pix;
    assign pix_sof    = w_head.sof;
    assign pix_eol    = w_head.eol;
    assign frame_done = (r_state == ST_DONE);
    assign underflow  = r_underflow;

    // ---------------- SRAM pins: released while enable=0 ----------------
    assign SRAM_ADDR = enable ? r_addr : {ADDR_W{1'bz}};
    assign SRAM_CE_N = enable ? 1'b0   : 1'bz;
    assign SRAM_OE_N = enable ? w_oe_n : 1'bz;
    assign SRAM_WE_N = enable ? 1'b1   : 1'bz;
    assign SRAM_UB_N = enable ? 1'b0   : 1'bz;
    assign SRAM_LB_N = enable ? 1'b0   : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_sram_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fb_reader
// Purpose  : Scoreboard testbench for sram_fb_reader on a reduced 64x20
//            frame. The SRAM model returns the low 16 address bits as data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fb_reader;

    localparam int H      = 64;
    localparam int V      = 20;
    localparam int PIXELS = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic        auto_rd;
    logic        rd_force;
    logic        pix_rd;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic        underflow;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
`ifdef FB_BYPASS_PATTERN_EN
    logic        pattern_sel;
`endif

    logic [17:0] sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] bar_tbl [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                                 16'hF81F, 16'h07FF, 16'hFFFF, 16'h0000};

    always #5 clk = ~clk;

    assign sram_dq = sram_addr[15:0];
    assign pix_rd  = auto_rd ? pix_valid : rd_force;

    sram_fb_reader #(
        .H_RES      (H),
        .V_RES      (V),
        .FIFO_DEPTH (16),
        .ADDR_W     (20)
    ) dut (
        .clk50       (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
`ifdef FB_BYPASS_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .frame_done  (frame_done),
        .underflow   (underflow),
        .SRAM_ADDR   (sram_addr),
        .SRAM_DQ     (sram_dq),
        .SRAM_CE_N   (ce_n),
        .SRAM_OE_N   (oe_n),
        .SRAM_WE_N   (we_n),
        .SRAM_UB_N   (ub_n),
        .SRAM_LB_N   (lb_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input bit pattern);
        logic [15:0] d;
        for (int i = 0; i < PIXELS; i++) begin
            d = i[15:0];
            if (pattern) d = bar_tbl[(i % H) / (H / 8)];
            sb_q.push_back({d, (i == 0), ((i % H) == H - 1)});
        end
    endtask

    task automatic push_range(input int n);
        for (int i = 0; i < n; i++)
            sb_q.push_back({i[15:0], (i == 0), ((i % H) == H - 1)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, sb_q.size() == 0}, 32'd1);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Monitor: a pop happens on the next rising edge; compare the head now.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && pix_valid && pix_rd && !frame_start) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got data %0h sof %0b eol %0b, expected no pixel",
                         pix_data, pix_sof, pix_eol);
            end else begin
                e = sb_q.pop_front();
                check("sb_pixel", {14'd0, pix_data, pix_sof, pix_eol}, {14'd0, e});
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; frame_start = 1'b0; auto_rd = 1'b0; rd_force = 1'b0;
`ifdef FB_BYPASS_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset values, idle bus state ----
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_sof", pix_sof, 0);
        check("rst_pix_eol", pix_eol, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underflow", underflow, 0);
        check("idle_oe_n", oe_n, 1);
        check("idle_ce_n", ce_n, 0);
        check("idle_we_n", we_n, 1);
        repeat (3) @(posedge clk); #1;
        check("idle_no_read", pix_valid, 0);

        // ---- frame 1: latency, fill to full, then full-frame drain ----
        pulse_frame_start();
        check("lat_e0_valid", pix_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_addr", sram_addr, 0);
        check("lat_e1_valid", pix_valid, 0);
        check("read_oe_n", oe_n, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", pix_valid, 1);
        check("lat_e2_sof", pix_sof, 1);
        repeat (30) @(posedge clk); #1;
        check("full_addr", sram_addr, 15);
        check("full_valid", pix_valid, 1);

        push_frame(1'b0);
        auto_rd = 1'b1;
        n = 0;
        while (sram_addr != 20'd1000 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("found_addr_1000", sram_addr, 1000);
        enable = 1'b0;                      // read of 1000 is in flight
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk); #1;
        check("reissue_1000", sram_addr, 1000);
        wait_drain("frame1_drain", 5000);
        check("frame1_done", frame_done, 1);
        check("frame1_underflow", underflow, 0);
        check("done_oe_n", oe_n, 1);
        check("frame1_empty", pix_valid, 0);

        // ---- frame 2: sticky underflow, then restart mid-frame ----
        auto_rd = 1'b0;
        pulse_frame_start();
        rd_force = 1'b1;                    // FIFO still empty here
        @(posedge clk); #1;
        rd_force = 1'b0;
        check("underflow_set", underflow, 1);
        check("underflow_no_pop", pix_valid, 0);
        push_range(290);
        auto_rd = 1'b1;
        wait_drain("frame2_partial", 2000);
        auto_rd = 1'b0;
        check("underflow_sticky", underflow, 1);
        repeat (25) @(posedge clk); #1;
        check("frame2_buffered", pix_valid, 1);
        auto_rd = 1'b1;                     // pop collides with frame_start
        pulse_frame_start();
        check("restart_flush", pix_valid, 0);
        check("restart_underflow", underflow, 0);
        check("restart_done", frame_done, 0);

        // ---- frame 3: full frame after restart ----
        push_frame(1'b0);
        wait_drain("frame3_drain", 5000);
        check("frame3_done", frame_done, 1);
        check("frame3_underflow", underflow, 0);

`ifdef FB_BYPASS_PATTERN_EN
        // ---- colour-bar source ----
        pattern_sel = 1'b1;
        push_frame(1'b1);
        pulse_frame_start();
        repeat (10) @(posedge clk); #1;
        check("pattern_oe_n", oe_n, 1);
        wait_drain("pattern_drain", 5000);
        check("pattern_done", frame_done, 1);
        pattern_sel = 1'b0;
`endif

        // ---- asynchronous reset mid-frame ----
        auto_rd = 1'b0;
        pulse_frame_start();
        repeat (10) @(posedge clk); #1;
        check("pre_rst_valid", pix_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", pix_valid, 0);
        check("async_rst_oe_n", oe_n, 1);
        @(posedge clk); #1 rst = 1'b0;
        check("post_rst_queue", {31'd0, sb_q.size() == 0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
